// File: rtl/rregs_chain_pkg.sv
// Shared definitions for the rregs register chain: minimum legal depth and the
// per-stage operation decode used by every flop stage.
package rregs_chain_pkg;

  localparam int unsigned MIN_DEPTH = 1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_RESET = 2'b10
  } stage_op_e;

  // Reset has priority over enable.
  function automatic stage_op_e stage_op(input logic rst_n, input logic en);
    if (!rst_n) return OP_RESET;
    return en ? OP_LOAD : OP_HOLD;
  endfunction

endpackage

// File: rtl/rregs_stage.sv
// One chain stage: WIDTH-bit data flop plus a valid flop, synchronous
// active-low reset and a load enable.
module rregs_stage
  import rregs_chain_pkg::*;
#(
  parameter int unsigned      WIDTH      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               RESET_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             vld_in,
  output logic [WIDTH-1:0] q,
  output logic             vld_out
);

  stage_op_e        op;
  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  always_comb begin
    op     = stage_op(rst_n, en);
    data_d = data_q;
    vld_d  = vld_q;
    case (op)
      OP_RESET: begin
        vld_d = 1'b0;
        // Without RESET_DATA the data flop simply holds through reset.
        if (RESET_DATA) data_d = RESET_VAL;
      end
      OP_LOAD: begin
        data_d = d;
        vld_d  = vld_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    vld_q  <= vld_d;
  end

  assign q       = data_q;
  assign vld_out = vld_q;

endmodule

// File: rtl/rregs_chain.sv
// Generic clocked register / DEPTH-stage delay line with per-stage taps,
// a valid shadow and a global enable.
module rregs_chain
  import rregs_chain_pkg::*;
#(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      DEPTH      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               RESET_DATA = 1'b1
) (
  output logic [WIDTH-1:0]            q,
  input  logic [WIDTH-1:0]            d,
  input  logic                        eph1,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        vld_in,
  output logic                        vld_out,
  output logic [DEPTH-1:0][WIDTH-1:0] taps
);

  if (DEPTH < MIN_DEPTH) begin : g_bad_depth
    $error("rregs_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    logic             stage_v;

    if (i == 0) begin : g_head
      assign stage_d = d;
      assign stage_v = vld_in;
    end else begin : g_body
      assign stage_d = taps[i-1];
      assign stage_v = vld[i-1];
    end

    rregs_stage #(
      .WIDTH      (WIDTH),
      .RESET_VAL  (RESET_VAL),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk     (eph1),
      .rst_n   (reset),
      .en      (en),
      .d       (stage_d),
      .vld_in  (stage_v),
      .q       (taps[i]),
      .vld_out (vld[i])
    );
  end

  assign q       = taps[DEPTH-1];
  assign vld_out = vld[DEPTH-1];

endmodule

// File: tb/tb_rregs_chain.sv
// Self-checking bench for rregs_chain: five configurations driven in lockstep,
// checked against a history-log model plus directed literal expectations.
module tb_rregs_chain;

  localparam int NI = 5;
  localparam int unsigned DEP [NI] = '{4, 1, 12, 3, 4};
  localparam int unsigned WID [NI] = '{8, 11, 128, 8, 8};
  localparam logic [127:0] RVS [NI] = '{128'h5A, 128'h0, 128'h0, 128'h5A, 128'h0};
  localparam bit RDAT [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [127:0] KEY = 128'hAB7F34AFDD7382220E089AFB3D909866;

  logic clk = 1'b0;
  logic [127:0] d_in [NI];
  logic en_in [NI], vin_in [NI], rst_in [NI];

  logic [7:0]          q0, q3, q4;
  logic [10:0]         q1;
  logic [127:0]        q2;
  logic [3:0][7:0]     taps0, taps4;
  logic [0:0][10:0]    taps1;
  logic [11:0][127:0]  taps2;
  logic [2:0][7:0]     taps3;
  logic vo0, vo1, vo2, vo3, vo4;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk     = 1'b0;

  always #5 clk = ~clk;

  rregs_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .RESET_DATA(1'b1)) u_stall (
    .q(q0), .d(d_in[0][7:0]), .eph1(clk), .reset(rst_in[0]), .en(en_in[0]),
    .vld_in(vin_in[0]), .vld_out(vo0), .taps(taps0));
  rregs_chain #(.WIDTH(11), .DEPTH(1), .RESET_VAL(11'h0), .RESET_DATA(1'b1)) u_reg (
    .q(q1), .d(d_in[1][10:0]), .eph1(clk), .reset(rst_in[1]), .en(en_in[1]),
    .vld_in(vin_in[1]), .vld_out(vo1), .taps(taps1));
  rregs_chain #(.WIDTH(128), .DEPTH(12), .RESET_VAL(128'h0), .RESET_DATA(1'b1)) u_key (
    .q(q2), .d(d_in[2]), .eph1(clk), .reset(rst_in[2]), .en(en_in[2]),
    .vld_in(vin_in[2]), .vld_out(vo2), .taps(taps2));
  rregs_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A), .RESET_DATA(1'b1)) u_rst3 (
    .q(q3), .d(d_in[3][7:0]), .eph1(clk), .reset(rst_in[3]), .en(en_in[3]),
    .vld_in(vin_in[3]), .vld_out(vo3), .taps(taps3));
  rregs_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00), .RESET_DATA(1'b0)) u_nors (
    .q(q4), .d(d_in[4][7:0]), .eph1(clk), .reset(rst_in[4]), .en(en_in[4]),
    .vld_in(vin_in[4]), .vld_out(vo4), .taps(taps4));

  function automatic logic [127:0] dut_tap(int k, int unsigned i);
    case (k)
      0:       return 128'(taps0[2'(i)]);
      1:       return 128'(taps1[0]);
      2:       return taps2[4'(i)];
      3:       return 128'(taps3[2'(i)]);
      default: return 128'(taps4[2'(i)]);
    endcase
  endfunction

  function automatic logic [127:0] dut_q(int k);
    case (k)
      0:       return 128'(q0);
      1:       return 128'(q1);
      2:       return q2;
      3:       return 128'(q3);
      default: return 128'(q4);
    endcase
  endfunction

  function automatic logic dut_vld(int k);
    case (k)
      0:       return vo0;
      1:       return vo1;
      2:       return vo2;
      3:       return vo3;
      default: return vo4;
    endcase
  endfunction

  function automatic logic [127:0] wmask(int k);
    if (WID[k] == 128) return '1;
    return (128'd1 << WID[k]) - 128'd1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model: log of values captured on enabled edges since the last reset.
  // Tap i holds the (i+1)-th most recent capture, or the reset value if none.
  logic [127:0] hbuf [NI][16];
  logic         hv   [NI][16];
  int unsigned  wp   [NI];
  int unsigned  cnt  [NI];

  initial begin
    for (int k = 0; k < NI; k++) begin
      wp[k]  = 0;
      cnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_in[k]) begin
        cnt[k] <= 0;
      end else if (en_in[k]) begin
        hbuf[k][wp[k]] <= d_in[k] & wmask(k);
        hv[k][wp[k]]   <= vin_in[k];
        wp[k]          <= (wp[k] + 1) % 16;
        cnt[k]         <= (cnt[k] < 16) ? cnt[k] + 1 : 16;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk) begin
        for (int k = 0; k < NI; k++) begin
          bit           ok;
          bit           q_known;
          logic [127:0] exp_v, exp_q;
          logic         exp_vld;
          int unsigned  last;
          ok      = 1'b1;
          q_known = 1'b0;
          exp_q   = '0;
          last    = DEP[k] - 1;
          for (int unsigned i = 0; i < DEP[k]; i++) begin
            if (cnt[k] > i) begin
              exp_v = hbuf[k][(wp[k] + 15 - i) % 16];
            end else begin
              exp_v = RVS[k];
            end
            if (cnt[k] > i || RDAT[k]) begin
              if (dut_tap(k, i) !== exp_v) ok = 1'b0;
              if (i == last) begin
                q_known = 1'b1;
                exp_q   = exp_v;
              end
            end
          end
          exp_vld = (cnt[k] > last) ? hv[k][(wp[k] + 15 - last) % 16] : 1'b0;
          if (q_known && dut_q(k) !== exp_q) ok = 1'b0;
          if (dut_vld(k) !== exp_vld) ok = 1'b0;
          n_tests++;
          if (!ok) begin
            n_fail++;
            $display("FAIL model_inst%0d t=%0t q=%h want_q=%h vld=%b want_vld=%b",
                     k, $time, dut_q(k), exp_q, dut_vld(k), exp_vld);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic rand_inst(input int k, input bit allow_reset);
    d_in[k]   = rand128();
    en_in[k]  = ($urandom_range(0, 3) != 0);
    vin_in[k] = $urandom_range(0, 1) != 0;
    rst_in[k] = allow_reset ? ($urandom_range(0, 15) != 0) : 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      d_in[k]   = rand128();
      en_in[k]  = 1'b1;
      vin_in[k] = 1'b0;
      rst_in[k] = 1'b0;
    end

    // Reset held for two edges
    @(negedge clk);
    chk = 1'b1;
    @(negedge clk);
    check("rst_q3",    128'(q3),    128'h5A);
    check("rst_taps3", 128'(taps3), 128'h5A5A5A);
    check("rst_vld3",  128'(vo3),   128'h0);
    check("rst_taps0", 128'(taps0), 128'h5A5A5A5A);

    // Directed phase: stall stream, single register, key chain
    for (int c = 1; c <= 13; c++) begin
      for (int k = 0; k < NI; k++) rst_in[k] = 1'b1;
      case (c)
        1: begin d_in[0] = 128'h01; en_in[0] = 1'b1; vin_in[0] = 1'b1; end
        2: begin d_in[0] = 128'h02; en_in[0] = 1'b1; vin_in[0] = 1'b1; end
        3, 4: begin d_in[0] = 128'hEE; en_in[0] = 1'b0; vin_in[0] = 1'b0; end
        5: begin d_in[0] = 128'h03; en_in[0] = 1'b1; vin_in[0] = 1'b1; end
        6: begin d_in[0] = 128'h04; en_in[0] = 1'b1; vin_in[0] = 1'b1; end
        default: begin d_in[0] = 128'h00; en_in[0] = 1'b1; vin_in[0] = 1'b0; end
      endcase
      en_in[1]  = 1'b1;
      vin_in[1] = 1'b0;
      case (c)
        1:       d_in[1] = 128'h001;
        2:       d_in[1] = 128'h002;
        3:       d_in[1] = 128'h400;
        default: d_in[1] = rand128();
      endcase
      en_in[2]  = 1'b1;
      d_in[2]   = (c == 1) ? KEY : rand128();
      vin_in[2] = (c == 1);
      rand_inst(3, 1'b0);
      rand_inst(4, 1'b0);
      @(negedge clk);
      if (c <= 3) check("single_reg_q", 128'(q1), (c == 1) ? 128'h001 : (c == 2) ? 128'h002 : 128'h400);
      if (c <= 12) check("key_tap", taps2[4'(c - 1)], KEY);
      if (c == 11) check("key_vld_early", 128'(vo2), 128'h0);
      if (c == 12) begin
        check("key_q",   q2, KEY);
        check("key_vld", 128'(vo2), 128'h1);
      end
      if (c == 3 || c == 4) check("stall_frozen", 128'(taps0), 128'h5A5A0102);
      if (c == 5) check("stall_q_pre", 128'(q0), 128'h5A);
      if (c >= 6 && c <= 9) check("stall_q_seq", 128'(q0), 128'(c - 5));
    end

    // Reset mid-stream on the DEPTH=4 chain
    for (int c = 0; c < 11; c++) begin
      d_in[0]   = (c < 6) ? rand128() : (c == 6) ? 128'hC3 : 128'h11;
      en_in[0]  = 1'b1;
      vin_in[0] = 1'b1;
      rst_in[0] = (c != 5);
      for (int k = 1; k < NI; k++) rand_inst(k, 1'b0);
      @(negedge clk);
      if (c == 5) begin
        check("midrst_taps", 128'(taps0), 128'h5A5A5A5A);
        check("midrst_vld",  128'(vo0),   128'h0);
      end
      if (c == 8) check("midrst_q_pre", 128'(q0), 128'h5A);
      if (c == 9) begin
        check("midrst_q_c3",  128'(q0), 128'hC3);
        check("midrst_vld_c3", 128'(vo0), 128'h1);
      end
    end

    // Randomized phase with occasional resets and stalls
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NI; k++) rand_inst(k, 1'b1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
